nibble_serial_add_ctrl: RTL and testbench
=========================================

# nibble_serial_add_ctrl

Sequencer that performs wide two's-complement addition (and optionally subtraction) by time-multiplexing one shared 4-bit `twos_comp_adder` instance across `NIBBLES` cycles.
- Latches wide operands on a start handshake.
- Feeds one nibble per cycle, least-significant first, through the adder, carrying between nibbles in a register.
- Reports the wide sum plus carry, overflow, negative and zero flags with a one-cycle done pulse.
- Sits between a register-file/ALU front end and the 4-bit adder datapath.

## Interface
Parameters:
- `NIBBLES`, 4, number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 2..16.

Ports:
- `clk_in` input 1: single clock; all state updates on the rising edge.
- `rst_n_in` input 1: reset, synchronous, active-low.
- `start_in` input 1: request; accepted only when `ready_out`=1.
- `a_in` input W: operand A, sampled on accept.
- `b_in` input W: operand B, sampled on accept.
- `carry_in` input 1: initial carry into nibble 0, sampled on accept.
- `sub_in` input 1: 1 = compute A−B. Exists only with `NSA_SUBTRACT_EN`.
- `ready_out` output 1: high in IDLE.
- `busy_out` output 1: high in RUN.
- `done_out` output 1: one-cycle pulse; results valid.
- `sum_out` output W: result, held until the next accept.
- `carry_out` output 1: carry out of the top nibble.
- `overflow` output 1: signed overflow of the W-bit result.
- `negative` output 1: true sign of the result, i.e. `sum_out[W-1]` XOR `overflow`.
- `zero` output 1: `sum_out` == 0.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `ready_out`=1.
  - On `start_in`=1, latch `a_in`, `b_in` and the initial carry, clear the nibble index and the zero accumulator, then go to RUN.
- **RUN:**
  - Each cycle, drive adder nibble i = index with the operand slices and the carry register.
  - Write the adder sum into `sum_out[4i+3:4i]` and the adder carry into the carry register.
  - Do not AND the adder's per-nibble zero flag into the zero accumulator. Compute `zero` from the completed `sum_out` as a separate step.
  - At index = NIBBLES−1, capture the adder's `carry_out`, `overflow` and `negative` into the output registers and go to DONE.
- **DONE:**
  - `done_out`=1 for exactly one cycle, with `zero` updated.
  - Unconditionally go to IDLE.
- **Arithmetic:**
  - Modulo 2^W.
  - Overflow is carry-into-MSB XOR carry-out-of-MSB, taken from the final nibble only.
  - Intermediate nibble overflow/negative outputs are ignored.
- **`start_in` outside IDLE:** ignored, not queued.
- **Operand inputs while not in IDLE:** don't-care.
- **Outputs between operations:**
  - `sum_out` and the flags update progressively during RUN.
  - They are stable from DONE until the next accept.
  - Consumers sample them on `done_out`.
- **Reset:**
  - `rst_n_in`=0 at any edge, including mid-RUN, forces IDLE.
  - Clears `sum_out`, `carry_out`, `overflow`, `negative`, `zero`, `done_out`, `busy_out` and the carry register to 0.
  - `ready_out` is 1 in the first cycle after reset is released.
  - An in-flight operation is discarded with no `done_out`.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..NIBBLES. `done_out` is high in cycle NIBBLES+1. `ready_out` returns in cycle NIBBLES+2.
- Latency from accept to `done_out` is NIBBLES+1 cycles. Throughput is one operation per NIBBLES+2 cycles.
- `start_in` held high continuously is re-accepted in every IDLE cycle. Back-to-back operations therefore have no extra gap.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- **`NSA_SUBTRACT_EN` defined:**
  - `sub_in` port exists.
  - On accept with `sub_in`=1, latch B as ~`b_in` and force the initial carry to 1; `carry_in` is ignored.
  - `carry_out`=1 means no borrow.
- **`NSA_SUBTRACT_EN` undefined:**
  - No `sub_in` port.
  - Add only, with `carry_in` as the initial carry.

## Test plan
All scenarios use NIBBLES=4.
- **Signed overflow:** reset then 0x7FFF+0x0001, `carry_in`=0 → `done_out` in cycle 5, `sum_out`=0x8000, `overflow`=1, `negative`=0, `carry_out`=0, `zero`=0.
- **Wrap to zero:** 0xFFFF+0x0001 → `sum_out`=0x0000, `carry_out`=1, `overflow`=0, `zero`=1, `negative`=0.
- **Carry-in only:** 0x1234+0x0000, `carry_in`=1 → `sum_out`=0x1235, all flags 0.
- **Subtraction (`NSA_SUBTRACT_EN`):** 0x0005−0x0007 → `sum_out`=0xFFFE, `carry_out`=0, `negative`=1, `overflow`=0. Then 0x8000−0x0001 → 0x7FFF, `overflow`=1, `negative`=1.
- **Start while busy:** pulse `start_in` with new operands in cycle 2 of RUN → ignored; the first result is unchanged; exactly one `done_out`.
- **Reset mid-RUN:** `rst_n_in`=0 in cycle 3 → no `done_out`, `sum_out`=0, `ready_out`=1 the cycle after release. A fresh 0x0001+0x0001 then yields 0x0002.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Wide two's-complement adder that time-multiplexes one 4-bit adder, LS nibble first.
// Define NSA_SUBTRACT_EN to add the sub_in port and A-B support.
module twos_comp_adder (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o,
   output logic       overflow_o,
   output logic       negative_o
);
   logic [4:0] full_s;
   logic [3:0] low_s;
   logic       ovf_s;

   // The carry into bit 3 comes from a 3-bit partial sum and is compared with the carry out.
   always_comb begin
      full_s     = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
      low_s      = {1'b0, a_i[2:0]} + {1'b0, b_i[2:0]} + {3'b000, cin_i};
      ovf_s      = low_s[3] ^ full_s[4];
      sum_o      = full_s[3:0];
      cout_o     = full_s[4];
      overflow_o = ovf_s;
      negative_o = full_s[3] ^ ovf_s;
   end
endmodule

module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 start_in,
   input  logic [4*NIBBLES-1:0] a_in,
   input  logic [4*NIBBLES-1:0] b_in,
   input  logic                 carry_in,
`ifdef NSA_SUBTRACT_EN
   input  logic                 sub_in,
`endif
   output logic                 ready_out,
   output logic                 busy_out,
   output logic                 done_out,
   output logic [4*NIBBLES-1:0] sum_out,
   output logic                 carry_out,
   output logic                 overflow,
   output logic                 negative,
   output logic                 zero
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t        state_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic [W-1:0]  sum_d;
   logic [IW-1:0] idx_q;
   logic          carry_q;
   logic          ready_q;
   logic          busy_q;
   logic          done_q;
   logic          cout_q;
   logic          ovf_q;
   logic          neg_q;
   logic          zero_q;

   logic [W-1:0]  b_load_s;
   logic          cin_load_s;
   logic [3:0]    a_slice_s;
   logic [3:0]    b_slice_s;
   logic [3:0]    add_sum_s;
   logic          add_cout_s;
   logic          add_ovf_s;
   logic          add_neg_s;

   // Operand B and the initial carry as they are latched on accept.
   always_comb begin
      b_load_s   = b_in;
      cin_load_s = carry_in;
`ifdef NSA_SUBTRACT_EN
      if (sub_in) begin
         b_load_s   = ~b_in;
         cin_load_s = 1'b1;
      end else begin
         b_load_s   = b_in;
         cin_load_s = carry_in;
      end
`endif
   end

   // Slice selection for the current nibble and the word as it will look after this write.
   always_comb begin
      a_slice_s = a_q[{idx_q, 2'b00} +: 4];
      b_slice_s = b_q[{idx_q, 2'b00} +: 4];
      sum_d     = sum_q;
      sum_d[{idx_q, 2'b00} +: 4] = add_sum_s;
   end

   twos_comp_adder u_adder (
      .a_i        (a_slice_s),
      .b_i        (b_slice_s),
      .cin_i      (carry_q),
      .sum_o      (add_sum_s),
      .cout_o     (add_cout_s),
      .overflow_o (add_ovf_s),
      .negative_o (add_neg_s)
   );

   // Sequencer state, operand latches and all registered outputs.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_in) begin
                  a_q     <= a_in;
                  b_q     <= b_load_s;
                  carry_q <= cin_load_s;
                  idx_q   <= '0;
                  zero_q  <= 1'b0;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_q   <= sum_d;
               carry_q <= add_cout_s;
               if (idx_q == LAST_IDX) begin
                  // Only the top nibble's flags describe the whole word.
                  cout_q  <= add_cout_s;
                  ovf_q   <= add_ovf_s;
                  neg_q   <= add_neg_s;
                  zero_q  <= (sum_d == '0);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready_out = ready_q;
   assign busy_out  = busy_q;
   assign done_out  = done_q;
   assign sum_out   = sum_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;
   assign negative  = neg_q;
   assign zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with NIBBLES=4.
module tb_nibble_serial_add_ctrl;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        carry_in;
   logic        sub;
   logic        ready_out;
   logic        busy_out;
   logic        done_out;
   logic [15:0] sum_out;
   logic        carry_out;
   logic        overflow;
   logic        negative;
   logic        zero;

   int vec_cnt = 0;
   int err_cnt = 0;

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
      .clk_in    (clk),
      .rst_n_in  (rst_n),
      .start_in  (start),
      .a_in      (a_in),
      .b_in      (b_in),
      .carry_in  (carry_in),
`ifdef NSA_SUBTRACT_EN
      .sub_in    (sub),
`endif
      .ready_out (ready_out),
      .busy_out  (busy_out),
      .done_out  (done_out),
      .sum_out   (sum_out),
      .carry_out (carry_out),
      .overflow  (overflow),
      .negative  (negative),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accepts one operation and stops at the done cycle; lat is -1 if done never arrives.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sb, output int lat);
      a_in = a; b_in = b; carry_in = cin; sub = sb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         if (done_out === 1'b1) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a_in = 16'h0; b_in = 16'h0; carry_in = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      vec_cnt++;
      if ({ready_out, busy_out, done_out} !== 3'b100) begin
         err_cnt++; $display("FAIL reset_ctrl got %b required 100", {ready_out, busy_out, done_out});
      end
      vec_cnt++;
      if ({sum_out, carry_out, overflow, negative, zero} !== 20'h0) begin
         err_cnt++; $display("FAIL reset_data got %h required 00000", {sum_out, carry_out, overflow, negative, zero});
      end
   endtask

   task automatic test_signed_overflow();
      int lat;
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
      vec_cnt++;
      if (lat !== 5) begin err_cnt++; $display("FAIL ovf_latency got %0d required 5", lat); end
      vec_cnt++;
      if ({sum_out, carry_out, overflow, negative, zero} !== {16'h8000, 4'b0100}) begin
         err_cnt++; $display("FAIL ovf_result got %h/%b required 8000/0100", sum_out, {carry_out, overflow, negative, zero});
      end
      @(posedge clk); #1;
      vec_cnt++;
      if ({done_out, ready_out, sum_out} !== {2'b01, 16'h8000}) begin
         err_cnt++; $display("FAIL ovf_after_done got %b%b %h required 01 8000", done_out, ready_out, sum_out);
      end
   endtask

   task automatic test_wrap_zero();
      int lat;
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
      vec_cnt++;
      if (lat !== 5) begin err_cnt++; $display("FAIL wrap_latency got %0d required 5", lat); end
      vec_cnt++;
      if ({sum_out, carry_out, overflow, negative, zero} !== {16'h0000, 4'b1001}) begin
         err_cnt++; $display("FAIL wrap_result got %h/%b required 0000/1001", sum_out, {carry_out, overflow, negative, zero});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_carry_in();
      int lat;
      do_op(16'h1234, 16'h0000, 1'b1, 1'b0, lat);
      vec_cnt++;
      if ({sum_out, carry_out, overflow, negative, zero} !== {16'h1235, 4'b0000} || lat !== 5) begin
         err_cnt++; $display("FAIL carry_in got %h/%b lat %0d required 1235/0000 lat 5", sum_out, {carry_out, overflow, negative, zero}, lat);
      end
      @(posedge clk); #1;
   endtask

`ifdef NSA_SUBTRACT_EN
   task automatic test_subtract();
      int lat;
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
      vec_cnt++;
      if ({sum_out, carry_out, overflow, negative, zero} !== {16'hFFFE, 4'b0010} || lat !== 5) begin
         err_cnt++; $display("FAIL sub_small got %h/%b required FFFE/0010", sum_out, {carry_out, overflow, negative, zero});
      end
      @(posedge clk); #1;
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
      vec_cnt++;
      if ({sum_out, carry_out, overflow, negative, zero} !== {16'h7FFF, 4'b1110} || lat !== 5) begin
         err_cnt++; $display("FAIL sub_ovf got %h/%b required 7FFF/1110", sum_out, {carry_out, overflow, negative, zero});
      end
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_start_while_busy();
      int dones = 0;
      int first = -1;
      logic [15:0] got = 16'h0;
      a_in = 16'h1111; b_in = 16'h2222; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         if (c == 2) begin start = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; end
         else start = 1'b0;
         if (done_out === 1'b1) begin
            dones++;
            if (first < 0) begin first = c; got = sum_out; end
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      vec_cnt++;
      if (dones !== 1 || first !== 5) begin
         err_cnt++; $display("FAIL busy_dones got %0d at %0d required 1 at 5", dones, first);
      end
      vec_cnt++;
      if (got !== 16'h3333) begin err_cnt++; $display("FAIL busy_sum got %h required 3333", got); end
   endtask

   task automatic test_reset_mid_run();
      int dones = 0;
      int lat;
      a_in = 16'hAAAA; b_in = 16'h1111; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      vec_cnt++;
      if ({ready_out, busy_out, done_out, sum_out} !== {3'b100, 16'h0000}) begin
         err_cnt++; $display("FAIL midrst_state got %b %h required 100 0000", {ready_out, busy_out, done_out}, sum_out);
      end
      for (int c = 0; c < 8; c++) begin
         if (done_out === 1'b1) dones++;
         @(posedge clk); #1;
      end
      vec_cnt++;
      if (dones !== 0) begin err_cnt++; $display("FAIL midrst_done got %0d required 0", dones); end
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
      vec_cnt++;
      if (sum_out !== 16'h0002 || lat !== 5) begin
         err_cnt++; $display("FAIL midrst_fresh got %h lat %0d required 0002 lat 5", sum_out, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int first = -1;
      int second = -1;
      logic [15:0] s1 = 16'h0;
      logic [15:0] s2 = 16'h0;
      a_in = 16'h0001; b_in = 16'h0002; carry_in = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a_in = 16'h0010; b_in = 16'h0020;
      for (int c = 1; c <= 30; c++) begin
         if (done_out === 1'b1) begin
            if (first < 0) begin first = c; s1 = sum_out; end
            else if (second < 0) begin second = c; s2 = sum_out; start = 1'b0; end
         end
         if (second >= 0) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      vec_cnt++;
      if (first !== 5 || second !== 11) begin
         err_cnt++; $display("FAIL b2b_timing got %0d,%0d required 5,11", first, second);
      end
      vec_cnt++;
      if (s1 !== 16'h0003 || s2 !== 16'h0030) begin
         err_cnt++; $display("FAIL b2b_sums got %h,%h required 0003,0030", s1, s2);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_signed_overflow();
      test_wrap_zero();
      test_carry_in();
`ifdef NSA_SUBTRACT_EN
      test_subtract();
`endif
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
